softmax_vec_seq: RTL and testbench
==================================

SOFTMAX_VEC_SEQ -- requirements
Module: softmax_vec_seq

Interface
REQ-001 Parameter N, default 64: lanes per vector.
REQ-002 Parameter W, default 16: bits per lane, Q-format opaque to this block.
REQ-003 Parameter DEPTH, default 256: maximum vectors per run; counters are $clog2(DEPTH+1) bits wide, written CW below.
REQ-004 Parameter MAX_OUT, default 4: maximum vectors in flight to the core.
REQ-005 Parameter TIMEOUT, default 1024: idle cycles allowed with vectors in flight.
REQ-006 Parameters ISTEP and KSTEP, defaults 1 and 3: per-lane and per-vector pattern increments.
REQ-007 Port clk, input, 1: the single clock; all logic is rising-edge.
REQ-008 Port rst, input, 1: asynchronous, active-low reset.
REQ-009 Port start, input, 1: single-cycle run request.
REQ-010 Port stop, input, 1: ends loop mode after in-flight vectors drain.
REQ-011 Port loop_mode, input, 1: 1 = repeat the run until stop.
REQ-012 Port num_vec, input, CW: vectors per run; values above DEPTH clamp to DEPTH.
REQ-013 Port seed, input, W: pattern base value.
REQ-014 Port en, output, 1: core enable.
REQ-015 Port valid_in, output, 1: single-cycle vector strobe to the core.
REQ-016 Port data, output, N*W: vector to the core; lane i occupies bits [i*W +: W].
REQ-017 Port valid_out, input, 1: core result strobe.
REQ-018 Port prob_flat, input, N*W: core result vector.
REQ-019 Port res_valid, output, 1: captured-result strobe.
REQ-020 Port res_idx, output, CW: index of the captured result.
REQ-021 Port res_data, output, N*W: captured result vector.
REQ-022 Ports busy, done and timeout_err, outputs, 1 bit each: status.

Function
REQ-023 States SHALL be IDLE, ISSUE, DRAIN, DONE and ERR.
REQ-024 Lane i of vector k SHALL equal (seed + k*KSTEP + i*ISTEP) mod 2^W.
REQ-025 In ISSUE, valid_in SHALL pulse with data only when outstanding < MAX_OUT and issued < num_vec, giving at most one vector per cycle.
REQ-026 Data SHALL remain stable from its valid_in cycle until the next valid_in.
REQ-027 outstanding SHALL increment on issue and decrement on valid_out; when both occur in the same cycle it SHALL be unchanged.
REQ-028 valid_out while outstanding = 0 SHALL be ignored and SHALL leave the count unchanged.
REQ-029 Each valid_out SHALL register prob_flat into res_data, with res_valid high for one cycle and res_idx equal to the return ordinal, all 1 cycle later.
REQ-030 ISSUE SHALL go to DRAIN when issued = num_vec.
REQ-031 DRAIN SHALL go to DONE when outstanding = 0.
REQ-032 In loop_mode with stop low, the transition to DONE SHALL instead go to ISSUE with the counters cleared and the same seed.
REQ-033 stop SHALL be sampled at any time and SHALL block further loops.
REQ-034 DONE SHALL hold done = 1 for one cycle, then go to IDLE.
REQ-035 start SHALL be accepted only in IDLE and ignored elsewhere; num_vec, seed and loop_mode SHALL be latched on acceptance.
REQ-036 A run with num_vec = 0 SHALL go IDLE -> DONE without asserting valid_in.
REQ-037 The timeout counter SHALL clear on valid_out or when outstanding = 0; reaching TIMEOUT SHALL go to ERR.
REQ-038 ERR SHALL keep timeout_err = 1 and en = 0 until the next start, which clears it and begins a new run.
REQ-039 en SHALL be 1 in ISSUE and DRAIN, and 0 otherwise.
REQ-040 busy SHALL be 1 in all states other than IDLE and ERR.

Reset
REQ-041 On rst low, the block SHALL asynchronously enter IDLE.
REQ-042 During reset, all outputs and counters SHALL be 0, including data and res_data.
REQ-043 Release of rst SHALL be synchronised internally; reset mid-run SHALL discard in-flight vectors, and late valid_out is ignored per REQ-028.

Structure
REQ-044 Shared package softmax_seq_pkg SHALL hold the state encoding, the CW function and the default parameter values.
REQ-045 The lane-pattern arithmetic SHALL sit in one sub-module, softmax_pat_gen (inputs seed and k; output N*W data), which is combinational.

Verification
REQ-046 Case: N=4, W=16, ISTEP=1, KSTEP=3, seed=0x0010, num_vec=2, core latency 5. Required: data lanes {0x10, 0x11, 0x12, 0x13} then {0x13, 0x14, 0x15, 0x16}; res_idx 0 then 1; done 1 cycle after the last res_valid.
REQ-047 Case: MAX_OUT=2, num_vec=6, core latency 10. Required: never more than 2 valid_in strobes unmatched by valid_out; exactly 6 results, in order.
REQ-048 Case: num_vec=0. Required: done asserted 2 cycles after start; valid_in never asserted.
REQ-049 Case: TIMEOUT=16, core never answers. Required: timeout_err = 1 and en = 0 at cycle 16 after the first valid_in; a later start clears it.
REQ-050 Case: loop_mode=1, num_vec=3, stop pulsed during the second pass. Required: 6 results, then done.
REQ-051 Case: rst pulled low during DRAIN. Required: all outputs 0 immediately; a stray valid_out after release produces no res_valid.

Source files
------------

// File: rtl/softmax_seq_pkg.sv
// Shared definitions for the softmax vector sequencer: state encoding,
// counter-width helper and default parameter values.
package softmax_seq_pkg;

  localparam int DEF_N       = 64;
  localparam int DEF_W       = 16;
  localparam int DEF_DEPTH   = 256;
  localparam int DEF_MAX_OUT = 4;
  localparam int DEF_TIMEOUT = 1024;
  localparam int DEF_ISTEP   = 1;
  localparam int DEF_KSTEP   = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int cw_of(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/softmax_pat_gen.sv
// Combinational test-pattern generator: lane i of vector k is
// seed + k*KSTEP + i*ISTEP, wrapping modulo 2^W.
module softmax_pat_gen
  import softmax_seq_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int W     = DEF_W,
  parameter int CW    = 8,
  parameter int ISTEP = DEF_ISTEP,
  parameter int KSTEP = DEF_KSTEP
) (
  input  logic [W-1:0]   seed,
  input  logic [CW-1:0]  k,
  output logic [N*W-1:0] data
);

  // Per-lane arithmetic; truncation to W bits gives the modulo wrap.
  always_comb begin
    data = '0;
    for (int i = 0; i < N; i++) begin
      data[i*W +: W] = seed + W'(k) * W'(KSTEP) + W'(i * ISTEP);
    end
  end

endmodule

// File: rtl/softmax_vec_seq.sv
// Softmax core sequencer: issues generated vectors to a core with a bounded
// number in flight, captures returned results, supports loop mode, stop and
// an idle timeout. Reset asserts asynchronously and releases synchronously.
//
// Handshake: there is no back-pressure. valid_in is a one-cycle strobe that
// qualifies data; the core answers every vector with a one-cycle valid_out
// strobe, in order. res_valid is a one-cycle strobe qualifying res_data and
// res_idx, one cycle after the matching valid_out.
module softmax_vec_seq
  import softmax_seq_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int W       = DEF_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int MAX_OUT = DEF_MAX_OUT,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int ISTEP   = DEF_ISTEP,
  parameter int KSTEP   = DEF_KSTEP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_mode,
  input  logic [cw_of(DEPTH)-1:0]  num_vec,
  input  logic [W-1:0]             seed,
  output logic                     en,
  output logic                     valid_in,
  output logic [N*W-1:0]           data,
  input  logic                     valid_out,
  input  logic [N*W-1:0]           prob_flat,
  output logic                     res_valid,
  output logic [cw_of(DEPTH)-1:0]  res_idx,
  output logic [N*W-1:0]           res_data,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output state_e                   dbg_state
);

  localparam int CW = cw_of(DEPTH);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0] sync_q, sync_d;
  logic       rst_n;

  state_e           state_q, state_d;
  logic             go_q, go_d, loop_q, loop_d, stop_q, stop_d;
  logic [CW-1:0]    num_q, num_d, issued_q, issued_d, ret_q, ret_d, ridx_q, ridx_d;
  logic [W-1:0]     seed_q, seed_d;
  logic [OW-1:0]    out_q, out_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             vin_q, vin_d, rv_q, rv_d;
  logic [N*W-1:0]   data_q, data_d, rdata_q, rdata_d, pat_data;
  logic             en_q, en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             accept, vo_acc, timed_out, issue;

  softmax_pat_gen #(.N(N), .W(W), .CW(CW), .ISTEP(ISTEP), .KSTEP(KSTEP)) u_pat (
    .seed (seed_q),
    .k    (issued_q),
    .data (pat_data)
  );

  // Reset release shifts a one through two flops before internal logic sees it.
  always_comb sync_d = {sync_q[0], 1'b1};

  // Reset synchroniser: clears immediately, releases after two edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b00;
    else      sync_q <= sync_d;
  end

  assign rst_n = sync_q[1];

  // Next-state, counters and registered-output decode.
  always_comb begin
    state_d  = state_q;
    go_d     = 1'b0;
    num_d    = num_q;
    seed_d   = seed_q;
    loop_d   = loop_q;
    stop_d   = stop_q | stop;
    issued_d = issued_q;
    ret_d    = ret_q;
    vin_d    = 1'b0;
    data_d   = data_q;
    rv_d     = 1'b0;
    ridx_d   = ridx_q;
    rdata_d  = rdata_q;

    accept    = start && !go_q && (state_q == S_IDLE || state_q == S_ERR);
    // A return with nothing in flight is a stray strobe and is dropped.
    vo_acc    = valid_out && (out_q != '0);
    timed_out = (state_q == S_ISSUE || state_q == S_DRAIN) && !vo_acc &&
                (out_q != '0) && (tmo_q == TW'(TIMEOUT - 1));
    issue     = (state_q == S_ISSUE) && !timed_out &&
                (out_q < OW'(MAX_OUT)) && (issued_q < num_q);

    // Run parameters are captured with start; the run begins one cycle later.
    if (accept) begin
      go_d   = 1'b1;
      num_d  = (num_vec > CW'(DEPTH)) ? CW'(DEPTH) : num_vec;
      seed_d = seed;
      loop_d = loop_mode;
    end
    if (issue) begin
      vin_d    = 1'b1;
      data_d   = pat_data;
      issued_d = issued_q + CW'(1);
    end
    if (vo_acc) begin
      rv_d    = 1'b1;
      rdata_d = prob_flat;
      ridx_d  = ret_q;
      ret_d   = ret_q + CW'(1);
    end
    case ({issue, vo_acc})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase
    tmo_d = (vo_acc || out_q == '0) ? '0 : tmo_q + TW'(1);

    case (state_q)
      S_IDLE, S_ERR: begin
        if (go_q) begin
          state_d  = (num_q == '0) ? S_DONE : S_ISSUE;
          issued_d = '0;
          ret_d    = '0;
          out_d    = '0;
          tmo_d    = '0;
          stop_d   = stop;
        end
      end
      S_ISSUE: begin
        if (timed_out)             state_d = S_ERR;
        else if (issued_q == num_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (timed_out) begin
          state_d = S_ERR;
        end else if (out_q == '0) begin
          if (loop_q && !stop_d) begin
            state_d  = S_ISSUE;
            issued_d = '0;
            ret_d    = '0;
            tmo_d    = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Entering ERR abandons whatever the core still holds.
    if (state_d == S_ERR && state_q != S_ERR) begin
      out_d = '0;
      tmo_d = '0;
    end

    en_d   = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    busy_d = (state_d != S_IDLE) && (state_d != S_ERR);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  // FSM, counters, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      go_q     <= 1'b0;
      num_q    <= '0;
      seed_q   <= '0;
      loop_q   <= 1'b0;
      stop_q   <= 1'b0;
      issued_q <= '0;
      ret_q    <= '0;
      out_q    <= '0;
      tmo_q    <= '0;
      vin_q    <= 1'b0;
      data_q   <= '0;
      rv_q     <= 1'b0;
      ridx_q   <= '0;
      rdata_q  <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      go_q     <= go_d;
      num_q    <= num_d;
      seed_q   <= seed_d;
      loop_q   <= loop_d;
      stop_q   <= stop_d;
      issued_q <= issued_d;
      ret_q    <= ret_d;
      out_q    <= out_d;
      tmo_q    <= tmo_d;
      vin_q    <= vin_d;
      data_q   <= data_d;
      rv_q     <= rv_d;
      ridx_q   <= ridx_d;
      rdata_q  <= rdata_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign en          = en_q;
  assign valid_in    = vin_q;
  assign data        = data_q;
  assign res_valid   = rv_q;
  assign res_idx     = ridx_q;
  assign res_data    = rdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_softmax_vec_seq.sv
// Bench for softmax_vec_seq: a latency-programmable core model answers every
// vector, a scoreboard holds expected results, a table drives normal runs and
// hand sequences cover empty run, timeout, loop/stop and reset mid-drain.
`timescale 1ns/1ps
module tb_softmax_vec_seq;
  import softmax_seq_pkg::*;

  localparam int N = 4, W = 16, DEPTH = 16, MAX_OUT = 2, TIMEOUT = 16;
  localparam int ISTEP = 1, KSTEP = 3;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = N * W;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0, rst = 1'b0;
  logic          start = 1'b0, stop = 1'b0, loop_mode = 1'b0;
  logic [CW-1:0] num_vec = '0;
  logic [W-1:0]  seed = '0;
  logic          en, valid_in, res_valid, busy, done, timeout_err;
  logic [NW-1:0] data, res_data;
  logic [CW-1:0] res_idx;
  state_e        dbg_state;
  logic          vo_core = 1'b0, vo_stray = 1'b0, valid_out;
  logic [NW-1:0] prob_flat = '0;

  assign valid_out = vo_core | vo_stray;

  always #5 clk = ~clk;

  softmax_vec_seq #(.N(N), .W(W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT),
                    .ISTEP(ISTEP), .KSTEP(KSTEP)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_mode(loop_mode),
    .num_vec(num_vec), .seed(seed), .en(en), .valid_in(valid_in), .data(data),
    .valid_out(valid_out), .prob_flat(prob_flat), .res_valid(res_valid),
    .res_idx(res_idx), .res_data(res_data), .busy(busy), .done(done),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0, n_errors = 0;
  int cyc = 0, core_lat = 5, start_cyc = 0;
  bit core_mute = 1'b0;
  logic [W-1:0] run_seed = '0;
  int run_num = 0;
  int vin_total, vo_total, res_total, done_cnt, done_cyc, last_res_cyc, first_vin_cyc, err_cyc;
  logic [NW-1:0] last_vin = '0;

  typedef struct { int due; logic [NW-1:0] d; } pend_t;
  pend_t         pend_q[$];
  logic [NW-1:0] exp_q[$];
  logic [CW-1:0] idx_q[$];
  logic [NW-1:0] vin_log[$];

  task automatic check(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NW-1:0] pat(input logic [W-1:0] s, input int k);
    logic [NW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(int'(s) + k * KSTEP + i * ISTEP);
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor, scoreboard and core model ----------------
  always @(negedge clk) begin
    pend_t p;
    int k;
    vo_core = 1'b0;
    if (rst) begin
      if (valid_in) begin
        if (vin_total == 0) first_vin_cyc = cyc;
        k = (run_num > 0) ? vin_total % run_num : vin_total;
        check("vin_data", data, pat(run_seed, k));
        vin_log.push_back(data);
        vin_total++;
        check("max_out", NW'(vin_total - vo_total <= MAX_OUT), NW'(1));
        last_vin = data;
        if (!core_mute) pend_q.push_back('{due: cyc + core_lat, d: data});
      end else if (vin_total > 0) begin
        check("data_stable", data, last_vin);
      end
      if (res_valid) begin
        res_total++;
        last_res_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL res_unexpected: got res_valid idx %0d, expected none", res_idx);
        end else begin
          check("res_data", res_data, exp_q.pop_front());
          check("res_idx", NW'(res_idx), NW'(idx_q.pop_front()));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (timeout_err && err_cyc < 0) err_cyc = cyc;
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        p = pend_q.pop_front();
        vo_core   = 1'b1;
        prob_flat = ~p.d ^ NW'(vo_total);
        exp_q.push_back(prob_flat);
        idx_q.push_back(CW'((run_num > 0) ? vo_total % run_num : vo_total));
        vo_total++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic [W-1:0] s, input int n, input bit lp);
    vin_total = 0; vo_total = 0; res_total = 0; done_cnt = 0;
    done_cyc = -1; last_res_cyc = -1; first_vin_cyc = -1; err_cyc = -1;
    vin_log.delete();
    run_seed = s;
    run_num  = (n > DEPTH) ? DEPTH : n;
    @(negedge clk);
    seed = s; num_vec = CW'(n); loop_mode = lp; start = 1'b1; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
    n_checks++;
    if (done_cnt == 0) begin
      n_errors++;
      $display("FAIL done_wait: got no done within %0d cycles, expected done", budget);
    end
    repeat (3) @(negedge clk);
  endtask

  typedef struct { logic [W-1:0] s; int n; int lat; int exp_n; } vec_t;
  vec_t tbl[4];

  // ---------------- test sequence ----------------
  initial begin
    tbl[0] = '{s: 16'h0010, n: 2,  lat: 5,  exp_n: 2};   // reference case
    tbl[1] = '{s: 16'h1234, n: 6,  lat: 10, exp_n: 6};   // throttled by MAX_OUT
    tbl[2] = '{s: 16'hFFFE, n: 3,  lat: 1,  exp_n: 3};   // lane wrap, fast core
    tbl[3] = '{s: 16'h0100, n: 20, lat: 2,  exp_n: 16};  // num_vec clamps to DEPTH

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ctrl", NW'({en, valid_in, res_valid, busy, done, timeout_err, res_idx}), NW'(0));
    check("rst_data", data, '0);
    check("rst_res", res_data, '0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_state", NW'(dbg_state), NW'(S_IDLE));

    // Table-driven runs
    for (int r = 0; r < 4; r++) begin
      core_lat = tbl[r].lat;
      start_run(tbl[r].s, tbl[r].n, 1'b0);
      wait_done(600);
      check("vin_count", NW'(vin_total), NW'(tbl[r].exp_n));
      check("res_count", NW'(res_total), NW'(tbl[r].exp_n));
      check("sb_empty", NW'(exp_q.size()), NW'(0));
      check("done_after_res", NW'(done_cyc - last_res_cyc), NW'(1));
      check("done_pulse", NW'(done_cnt), NW'(1));
      check("idle_after", NW'({busy, en}), NW'(0));
      if (r == 0) begin
        check("ref_vec0", vin_log[0], 64'h0013_0012_0011_0010);
        check("ref_vec1", vin_log[1], 64'h0016_0015_0014_0013);
      end
    end

    // Empty run
    start_run(16'h0042, 0, 1'b0);
    wait_done(20);
    check("empty_done_lat", NW'(done_cyc - start_cyc), NW'(2));
    check("empty_no_vin", NW'(vin_total), NW'(0));

    // Timeout: core never answers
    core_mute = 1'b1;
    start_run(16'h0500, 2, 1'b0);
    for (int i = 0; i < 100 && err_cyc < 0; i++) @(negedge clk);
    check("tmo_latency", NW'(err_cyc - first_vin_cyc), NW'(TIMEOUT));
    check("tmo_flags", NW'({timeout_err, en, busy}), NW'(3'b100));
    repeat (5) @(negedge clk);
    check("tmo_hold", NW'(timeout_err), NW'(1));
    core_mute = 1'b0;
    core_lat  = 4;
    start_run(16'h0600, 1, 1'b0);
    wait_done(100);
    check("tmo_cleared", NW'(timeout_err), NW'(0));
    check("tmo_rerun_res", NW'(res_total), NW'(1));

    // Loop mode, stop during second pass
    core_lat = 3;
    start_run(16'h0A00, 3, 1'b1);
    for (int i = 0; i < 200 && vin_total < 4; i++) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    loop_mode = 1'b0;
    wait_done(300);
    check("loop_res", NW'(res_total), NW'(6));
    check("loop_vin", NW'(vin_total), NW'(6));
    check("loop_done", NW'(done_cnt), NW'(1));

    // Reset during DRAIN, then a stray valid_out
    core_lat = 20;
    start_run(16'h0700, 2, 1'b0);
    for (int i = 0; i < 100 && dbg_state != S_DRAIN; i++) @(negedge clk);
    check("reach_drain", NW'(dbg_state), NW'(S_DRAIN));
    rst = 1'b0;
    #1;
    check("mid_rst_ctrl", NW'({en, valid_in, res_valid, busy, done, timeout_err, res_idx}), NW'(0));
    check("mid_rst_data", data, '0);
    check("mid_rst_res", res_data, '0);
    pend_q.delete(); exp_q.delete(); idx_q.delete();
    last_vin = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    res_total = 0;
    vo_stray = 1'b1;
    @(negedge clk);
    vo_stray = 1'b0;
    repeat (4) @(negedge clk);
    check("stray_ignored", NW'(res_total), NW'(0));
    check("stray_idle", NW'({busy, dbg_state}), NW'(S_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 ns, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
